// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter using reverse double-dabble.
// One right shift per clock over {bcd_reg, bin_reg}, then any BCD nibble >= 8
// has 3 subtracted. BIN_W iterations produce the binary value in bin_reg.
// A capture containing a digit > 9 completes immediately with err=1, bin=0.
module bcd2bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic longint unsigned max_decimal();
        longint unsigned v;
        v = 1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

    // The largest DIGITS-digit decimal value must fit in BIN_W bits.
    generate
        if (!(max_decimal() < (64'd1 << BIN_W))) begin : g_width_check
            $error("bcd2bin_seq: BIN_W=%0d too narrow for DIGITS=%0d", BIN_W, DIGITS);
        end
    endgenerate

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               bcd_bad;
    logic [SR_W-1:0]    sr_shift;
    logic [SR_W-1:0]    sr_adj;

    // Flag any input digit outside 0..9.
    always_comb begin
        bcd_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) begin
                bcd_bad = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: shift right, then correct each BCD nibble >= 8.
    always_comb begin
        sr_shift = sr_q >> 1;
        sr_adj   = sr_shift;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sr_shift[BIN_W + 4*i +: 4] >= 4'd8) begin
                sr_adj[BIN_W + 4*i +: 4] = sr_shift[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    // Next-state and result logic for the IDLE/CONV controller.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (bcd_bad) begin
                        bin_d  = '0;
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        sr_d    = {bcd, {BIN_W{1'b0}}};
                        cnt_d   = CNT_W'(BIN_W);
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                sr_d  = sr_adj;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bin_d   = sr_adj[BIN_W-1:0];
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign bin  = bin_q;
    assign err  = err_q;
    assign done = done_q;
    assign busy = (state_q == CONV);

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Testbench for bcd2bin_seq: directed scenarios plus random and exhaustive
// inputs, checked against a decimal-arithmetic reference model.
module tb_bcd2bin_seq;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [4*DIGITS-1:0] bcd;
    logic [BIN_W-1:0]    bin;
    logic                busy;
    logic                done;
    logic                err;

    int total;
    int passed;

    bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bcd   (bcd),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal value of a packed BCD word, and whether any digit > 9.
    function automatic int ref_value(input logic [11:0] v);
        int acc;
        int w;
        acc = 0;
        w   = 1;
        for (int i = 0; i < DIGITS; i++) begin
            acc = acc + int'(v[4*i +: 4]) * w;
            w   = w * 10;
        end
        return acc;
    endfunction

    function automatic bit ref_bad(input logic [11:0] v);
        bit b;
        b = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) b = 1'b1;
        end
        return b;
    endfunction

    // Reference binary-to-BCD, used for the round-trip check.
    function automatic logic [11:0] ref_bin2bcd(input int n);
        logic [11:0] r;
        int x;
        r = '0;
        x = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [11:0] v);
        bcd   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for done after an accept edge; report latency and whether busy held.
    task automatic wait_done(output int lat, output bit busy_held);
        lat       = 0;
        busy_held = 1'b1;
        while (!done && lat < 20) begin
            if (!busy) busy_held = 1'b0;
            tick();
            lat++;
        end
    endtask

    // Full conversion: accept, wait, check latency, result, flags, and single-cycle done.
    task automatic convert_check(input string tag, input logic [11:0] v);
        int lat;
        bit bh;
        int exp_lat;
        accept(v);
        exp_lat = ref_bad(v) ? 0 : BIN_W;
        wait_done(lat, bh);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (!ref_bad(v)) chk({tag, " busy held"}, 32'(bh), 32'd1);
        chk({tag, " bin"}, 32'(bin), ref_bad(v) ? 32'd0 : 32'(ref_value(v)));
        chk({tag, " err"}, 32'(err), 32'(ref_bad(v)));
        chk({tag, " busy at done"}, 32'(busy), 32'd0);
        tick();
        chk({tag, " done pulse width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        bit bh;
        int pulses;
        logic [11:0] rv;
        logic [11:0] rt;

        total  = 0;
        passed = 0;
        start  = 1'b0;
        bcd    = '0;
        rst_n  = 1'b0;
        #12;
        chk("reset bin", 32'(bin), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        convert_check("255", 12'h255);
        convert_check("999", 12'h999);
        convert_check("000", 12'h000);
        convert_check("1A3", 12'h1A3);
        convert_check("042", 12'h042);

        // start during CONV ignored
        accept(12'h128);
        pulses = 0;
        tick();
        bcd   = 12'h777;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (done) pulses++;
            tick();
        end
        chk("ignore start pulses", 32'(pulses), 32'd1);
        chk("ignore start bin", 32'(bin), 32'd128);

        // back-to-back: start on the done cycle
        accept(12'h300);
        wait_done(lat, bh);
        chk("b2b first latency", 32'(lat), 32'd10);
        chk("b2b first bin", 32'(bin), 32'd300);
        accept(12'h001);
        wait_done(lat, bh);
        chk("b2b second latency", 32'(lat), 32'd10);
        chk("b2b second bin", 32'(bin), 32'd1);
        tick();

        // reset mid-conversion
        accept(12'h512);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("abort bin", 32'(bin), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort err", 32'(err), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            tick();
        end
        chk("abort no done", 32'(pulses), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        convert_check("064", 12'h064);

        // held start: conversions restart on every IDLE entry
        bcd   = 12'h123;
        start = 1'b1;
        tick();
        wait_done(lat, bh);
        chk("held first latency", 32'(lat), 32'd10);
        tick();
        wait_done(lat, bh);
        chk("held restart latency", 32'(lat), 32'd10);
        chk("held restart bin", 32'(bin), 32'd123);
        start = 1'b0;
        tick();
        tick();

        // random words, including invalid digits
        for (int i = 0; i < 40; i++) begin
            rv = 12'($urandom);
            convert_check("random", rv);
        end

        // exhaustive round trip over all valid inputs
        for (int n = 0; n < 1000; n++) begin
            accept(ref_bin2bcd(n));
            wait_done(lat, bh);
            rt = ref_bin2bcd(int'(bin));
            chk("exhaustive bin", 32'(bin), 32'(n));
            chk("exhaustive round trip", 32'(rt), 32'(ref_bin2bcd(n)));
            chk("exhaustive err", 32'(err), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
